// File: rtl/alu_seq_pkg.sv
// Shared definitions for the register-file/ALU sequencer: FSM state encoding
// and default datapath widths.
package alu_seq_pkg;

  localparam int unsigned DATA_W_DEF = 4;
  localparam int unsigned ADDR_W_DEF = 2;
  localparam int unsigned OP_W_DEF   = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/alu_regfile_sequencer.sv
// Four-phase control stage (IDLE/READ/EXEC/WRITE) driving a register file and ALU.
// Optional status flags are enabled with the SEQ_FLAGS_EN macro.
module alu_regfile_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned OP_W   = OP_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   instr_op,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_rs1,
  input  logic [ADDR_W-1:0] instr_rs2,
  input  logic [DATA_W-1:0] instr_imm,
  input  logic              instr_use_imm,
  input  logic              instr_wb,
  output logic [ADDR_W-1:0] rf_rd1,
  output logic [ADDR_W-1:0] rf_rd2,
  input  logic [DATA_W-1:0] rf_data_out1,
  input  logic [DATA_W-1:0] rf_data_out2,
  output logic [ADDR_W-1:0] rf_wr,
  output logic              rf_write_enable,
  output logic [DATA_W-1:0] rf_data_in,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  output logic              done,
  output logic [DATA_W-1:0] result
`ifdef SEQ_FLAGS_EN
  ,
  output logic              flag_zero,
  output logic              flag_carry
`endif
);

  seq_state_e        r_state, w_state_nxt;
  logic [OP_W-1:0]   r_op;
  logic [ADDR_W-1:0] r_rd, r_rs1, r_rs2;
  logic [DATA_W-1:0] r_imm, r_opa, r_opb, r_res, r_result;
  logic              r_use_imm, r_wb;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (instr_valid) w_state_nxt = S_READ;
      S_READ:  w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_WRITE;
      S_WRITE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op      <= '0;
      r_rd      <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_imm     <= '0;
      r_use_imm <= 1'b0;
      r_wb      <= 1'b0;
      r_opa     <= '0;
      r_opb     <= '0;
      r_res     <= '0;
      r_result  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (instr_valid) begin
          r_op      <= instr_op;
          r_rd      <= instr_rd;
          r_rs1     <= instr_rs1;
          r_rs2     <= instr_rs2;
          r_imm     <= instr_imm;
          r_use_imm <= instr_use_imm;
          r_wb      <= instr_wb;
        end
        S_READ: begin
          r_opa <= rf_data_out1;
          r_opb <= r_use_imm ? r_imm : rf_data_out2;
        end
        S_EXEC:  r_res    <= alu_result;
        S_WRITE: r_result <= r_res;
        default: ;
      endcase
    end
  end

`ifdef SEQ_FLAGS_EN
  logic r_cy, r_flag_zero, r_flag_carry;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cy         <= 1'b0;
      r_flag_zero  <= 1'b0;
      r_flag_carry <= 1'b0;
    end else begin
      if (r_state == S_EXEC) r_cy <= alu_carry;
      if (r_state == S_WRITE) begin
        r_flag_zero  <= (r_res == '0);
        r_flag_carry <= r_cy;
      end
    end
  end

  assign flag_zero  = r_flag_zero;
  assign flag_carry = r_flag_carry;
`else
  // Carry has no consumer without the flag outputs.
  logic w_unused_carry;
  assign w_unused_carry = alu_carry;
`endif

  // Addresses/operands are driven from the field registers in every state,
  // so they hold their last captured values when not in use.
  assign instr_ready     = (r_state == S_IDLE);
  assign rf_rd1          = r_rs1;
  assign rf_rd2          = r_rs2;
  assign alu_op          = r_op;
  assign alu_a           = r_opa;
  assign alu_b           = r_opb;
  assign rf_wr           = r_rd;
  assign rf_data_in      = r_res;
  assign rf_write_enable = (r_state == S_WRITE) && r_wb;
  assign done            = (r_state == S_WRITE);
  assign result          = r_result;

endmodule

// File: tb/tb_alu_regfile_sequencer.sv
// Scoreboard bench for alu_regfile_sequencer with a behavioural register file
// and ALU; flag checks are included when SEQ_FLAGS_EN is defined.
module tb_alu_regfile_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [2:0] instr_op = '0;
  logic [1:0] instr_rd = '0, instr_rs1 = '0, instr_rs2 = '0;
  logic [3:0] instr_imm = '0;
  logic       instr_use_imm = 1'b0, instr_wb = 1'b0;
  logic [1:0] rf_rd1, rf_rd2, rf_wr;
  logic [3:0] rf_data_out1, rf_data_out2, rf_data_in;
  logic       rf_write_enable;
  logic [2:0] alu_op;
  logic [3:0] alu_a, alu_b, alu_result;
  logic       alu_carry;
  logic       done;
  logic [3:0] result;
`ifdef SEQ_FLAGS_EN
  logic       flag_zero, flag_carry;
`endif

  alu_regfile_sequencer #(.DATA_W(4), .ADDR_W(2), .OP_W(3)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1),
    .instr_rs2(instr_rs2), .instr_imm(instr_imm),
    .instr_use_imm(instr_use_imm), .instr_wb(instr_wb),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .rf_data_out1(rf_data_out1), .rf_data_out2(rf_data_out2),
    .rf_wr(rf_wr), .rf_write_enable(rf_write_enable), .rf_data_in(rf_data_in),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_carry(alu_carry),
`ifdef SEQ_FLAGS_EN
    .flag_zero(flag_zero), .flag_carry(flag_carry),
`endif
    .done(done), .result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural register file with a bench-side preload port.
  logic [3:0] rf [4];
  logic       ld_en = 1'b0;
  logic [1:0] ld_addr = '0;
  logic [3:0] ld_data = '0;
  always @(posedge clk) begin
    if (rf_write_enable) rf[rf_wr] <= rf_data_in;
    else if (ld_en)      rf[ld_addr] <= ld_data;
  end
  assign rf_data_out1 = rf[rf_rd1];
  assign rf_data_out2 = rf[rf_rd2];

  // ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, others pass B.
  always_comb begin
    alu_carry  = 1'b0;
    alu_result = alu_b;
    case (alu_op)
      3'd0: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: {alu_carry, alu_result} = {1'b0, alu_a} - {1'b0, alu_b};
      3'd2: alu_result = alu_a & alu_b;
      3'd3: alu_result = alu_a | alu_b;
      3'd4: alu_result = alu_a ^ alu_b;
      default: alu_result = alu_b;
    endcase
  end

  typedef struct {
    logic       wb;
    logic [1:0] rd;
    logic [3:0] res;
    logic       cy;
    logic       z;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic load(input logic [1:0] a, input logic [3:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic [3:0] imm, input logic ui,
                       input logic wb, input logic hold, input logic push,
                       input logic [3:0] eres, input logic ecy, input logic ez,
                       output int acc);
    int n;
    @(negedge clk);
    instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
    instr_imm = imm; instr_use_imm = ui; instr_wb = wb; instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      instr_valid = 1'b0;
      acc = -1;
    end else begin
      @(posedge clk);
      #1;
      acc = cyc;
      // done is visible at the falling edge two rising edges after the accept edge
      if (push) sb.push_back('{wb: wb, rd: rd, res: eres, cy: ecy, z: ez, cyc: acc + 2});
      if (!hold) instr_valid = 1'b0;
    end
  endtask

  logic       pend = 1'b0;
  exp_t       pend_e;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (pend) begin
        chk("result_after_done", result, pend_e.res);
`ifdef SEQ_FLAGS_EN
        chk("flag_zero", flag_zero, pend_e.z);
        chk("flag_carry", flag_carry, pend_e.cy);
`endif
        pend = 1'b0;
      end
      if (rf_write_enable && !done) chk("stray_write_enable", rf_write_enable, 1'b0);
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", done, 1'b0);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("write_enable", rf_write_enable, e.wb);
          if (e.wb) chk("rf_wr", rf_wr, e.rd);
          chk("rf_data_in", rf_data_in, e.res);
          pend_e = e;
          pend = 1'b1;
        end
      end
    end
  end

  initial begin
    int a1, a2, n;
    repeat (3) @(negedge clk);
    chk("reset_done", done, 1'b0);
    chk("reset_wen", rf_write_enable, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_ready", instr_ready, 1'b1);
    chk("reset_result", result, 4'h0);
    chk("reset_rf_wr", rf_wr, 2'd0);
    chk("reset_alu_a", alu_a, 4'h0);

    load(2'd0, 4'h1); load(2'd1, 4'h5); load(2'd2, 4'h3); load(2'd3, 4'h0);

    // R3 = R1 + R2 = 8
    issue(3'd0, 2'd3, 2'd1, 2'd2, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h8, 1'b0, 1'b0, a1);
    repeat (5) @(negedge clk);
    chk("rf3_after_add", rf[3], 4'h8);

    // Reset while the instruction is in EXEC: no write, no done.
    issue(3'd0, 2'd3, 2'd3, 2'd0, 4'h1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h9, 1'b0, 1'b0, a1);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_wen", rf_write_enable, 1'b0);
      chk("abort_done", done, 1'b0);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("abort_ready", instr_ready, 1'b1);
    chk("abort_result_cleared", result, 4'h0);
    chk("abort_rf3_kept", rf[3], 4'h8);

    // R0 + 0xF wraps to 0 with carry
    issue(3'd0, 2'd1, 2'd0, 2'd3, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 1'b1, a1);
    // wb=0: 8 & 0xC = 8, R2 untouched
    issue(3'd2, 2'd2, 2'd3, 2'd0, 4'hC, 1'b1, 1'b0, 1'b0, 1'b1, 4'h8, 1'b0, 1'b0, a1);
    // 1 - 3 borrows: 0xE with carry
    issue(3'd1, 2'd0, 2'd0, 2'd0, 4'h3, 1'b1, 1'b0, 1'b0, 1'b1, 4'hE, 1'b1, 1'b0, a1);
    repeat (5) @(negedge clk);
    chk("rf2_no_wb", rf[2], 4'h3);

    // Back-to-back with valid held: R1 <= 8-1 = 7, then R1 | 0 = 7
    issue(3'd1, 2'd1, 2'd3, 2'd0, 4'h1, 1'b1, 1'b1, 1'b1, 1'b1, 4'h7, 1'b0, 1'b0, a1);
    issue(3'd3, 2'd0, 2'd1, 2'd0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h7, 1'b0, 1'b0, a2);
    chk("b2b_accept_spacing", a2 - a1, 32'd4);

    // rd = rs1 = rs2 = 2, R2 = 6 -> 0xC
    repeat (5) @(negedge clk);
    load(2'd2, 4'h6);
    issue(3'd0, 2'd2, 2'd2, 2'd2, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 4'hC, 1'b0, 1'b0, a1);
    issue(3'd3, 2'd0, 2'd2, 2'd0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 4'hC, 1'b0, 1'b0, a1);

    n = 0;
    while ((sb.size() != 0 || pend) && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    chk("rf2_final", rf[2], 4'hC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
